cpu_ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the CPU datapath. It walks a fetch / decode / execute cycle and drives the single-cycle enable strobes of the enable-gated D flip-flop registers (PC, IR, ACC). It also drives the memory read/write handshake and the ALU operation select. It sits between the instruction register output and the register-enable, memory-control and ALU-control inputs of the datapath.

---
 rtl/cpu_ctrl_pkg.sv | 51 +++++
 rtl/cpu_ctrl_wait_timer.sv | 31 +++
 rtl/cpu_ctrl_seq.sv | 133 +++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, ALU codes, state encoding.
// The optional memory-wait timeout is enabled with the CPU_CTRL_TIMEOUT_EN macro.
package cpu_ctrl_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_JMP   = 4'h7;
   localparam logic [3:0] OP_JZ    = 4'h8;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;

   localparam int WAIT_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM_RD = 3'd3,
      ST_MEM_WR = 3'd4,
      ST_HALT   = 3'd5,
      ST_FAULT  = 3'd6
   } state_e;

   function automatic logic [2:0] alu_decode(input logic [3:0] op);
      logic [2:0] r;
      case (op)
         OP_ADD:  r = ALU_ADD;
         OP_SUB:  r = ALU_SUB;
         OP_AND:  r = ALU_AND;
         OP_OR:   r = ALU_OR;
         default: r = ALU_PASS;
      endcase
      return r;
   endfunction

   function automatic logic is_mem_read_op(input logic [3:0] op);
      return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_AND)  || (op == OP_OR);
   endfunction

endpackage

// File: rtl/cpu_ctrl_wait_timer.sv
// Memory-wait counter with terminal compare; used only when CPU_CTRL_TIMEOUT_EN is defined.
// Counts consecutive cycles spent in a wait state without mem_ready.
module ctrl_wait_timer
   import cpu_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic active_i,
   input  logic ready_i,
   output logic expire_o
);

   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

   // Clearing whenever not waiting (or on completion) makes every wait-state entry start at 0.
   always_comb begin
      cnt_d = cnt_q;
      if (!active_i || ready_i) cnt_d = '0;
      else                      cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire_o = active_i && !ready_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle fetch/decode/execute control sequencer driving datapath enables and memory handshake.
// Define CPU_CTRL_TIMEOUT_EN to add the bounded memory-wait timeout and the FAULT state.
module cpu_ctrl_seq
   import cpu_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       pc_sel,
   output logic       ir_en,
   output logic       acc_en,
   output logic       addr_sel,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [2:0] alu_op,
   output logic       busy,
   output logic       halted,
   output logic       fault
);

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("cpu_ctrl_seq: TIMEOUT must be within 2..255");
   end

   state_e     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic       timeout_w;

`ifdef CPU_CTRL_TIMEOUT_EN
   logic in_wait_w;
   assign in_wait_w = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

   ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .active_i (in_wait_w),
      .ready_i  (mem_ready),
      .expire_o (timeout_w)
   );
`else
   assign timeout_w = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready)      state_d = ST_DECODE;
            else if (timeout_w) state_d = ST_FAULT;
         end
         ST_DECODE: begin
            op_d = opcode;
            if (opcode == OP_HALT)          state_d = ST_HALT;
            else if (is_mem_read_op(opcode)) state_d = ST_MEM_RD;
            else if (opcode == OP_STORE)    state_d = ST_MEM_WR;
            else                            state_d = ST_FETCH;
         end
         ST_MEM_RD, ST_MEM_WR: begin
            if (mem_ready)      state_d = ST_FETCH;
            else if (timeout_w) state_d = ST_FAULT;
         end
         ST_HALT:   state_d = ST_HALT;
         ST_FAULT:  state_d = ST_FAULT;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Requests are Moore on state; enables also qualify on inputs and are suppressed under reset.
   always_comb begin
      pc_en    = 1'b0;
      pc_sel   = 1'b0;
      ir_en    = 1'b0;
      acc_en   = 1'b0;
      addr_sel = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      alu_op   = ALU_PASS;
      busy     = 1'b0;
      halted   = 1'b0;
      fault    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            busy   = 1'b1;
            mem_rd = 1'b1;
            ir_en  = mem_ready && !reset;
            pc_en  = mem_ready && !reset;
         end
         ST_DECODE: begin
            busy = 1'b1;
            if (!reset && ((opcode == OP_JMP) || ((opcode == OP_JZ) && zero))) begin
               pc_en  = 1'b1;
               pc_sel = 1'b1;
            end
         end
         ST_MEM_RD: begin
            busy     = 1'b1;
            mem_rd   = 1'b1;
            addr_sel = 1'b1;
            alu_op   = alu_decode(op_q);
            acc_en   = mem_ready && !reset;
         end
         ST_MEM_WR: begin
            busy     = 1'b1;
            mem_wr   = 1'b1;
            addr_sel = 1'b1;
         end
         ST_HALT:   halted = 1'b1;
`ifdef CPU_CTRL_TIMEOUT_EN
         ST_FAULT:  fault = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: directed table, hand-built corner sequences and
// randomized instruction streams whose expected per-cycle outputs come from instruction-level rules.
module tb_cpu_ctrl_seq;

   logic       clk = 1'b0;
   logic       reset, start, zero, mem_ready;
   logic [3:0] opcode;
   logic       pc_en, pc_sel, ir_en, acc_en, addr_sel, mem_rd, mem_wr, busy, halted, fault;
   logic [2:0] alu_op;

   always #5 clk = ~clk;

   cpu_ctrl_seq #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .pc_sel(pc_sel), .ir_en(ir_en),
      .acc_en(acc_en), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .alu_op(alu_op), .busy(busy), .halted(halted), .fault(fault)
   );

   // Expected-output bit layout: pc_en pc_sel ir_en acc_en addr_sel mem_rd mem_wr alu[3] busy halted fault
   localparam logic [12:0] B_PCEN  = 13'h1000;
   localparam logic [12:0] B_PCSEL = 13'h0800;
   localparam logic [12:0] B_IREN  = 13'h0400;
   localparam logic [12:0] B_ACCEN = 13'h0200;
   localparam logic [12:0] B_ASEL  = 13'h0100;
   localparam logic [12:0] B_MRD   = 13'h0080;
   localparam logic [12:0] B_MWR   = 13'h0040;
   localparam logic [12:0] B_BUSY  = 13'h0004;
   localparam logic [12:0] B_HALT  = 13'h0002;
   localparam logic [12:0] B_FAULT = 13'h0001;
   localparam logic [12:0] E_NONE  = 13'h0000;

`ifdef CPU_CTRL_TIMEOUT_EN
   localparam int STORE_WAITS = 3;
`else
   localparam int STORE_WAITS = 5;
`endif

   typedef struct {
      logic        rst;
      logic        st;
      logic [3:0]  op;
      logic        z;
      logic        rdy;
      logic        chk;
      logic [12:0] exp;
      int          tag;
   } vec_t;

   vec_t dir_tbl[7];
   vec_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [12:0] alu_field(input logic [3:0] op);
      logic [2:0] a;
      a = (op == 4'd1) ? 3'd0 : 3'(op - 4'd2);
      return {7'b0, a, 3'b0};
   endfunction

   function automatic vec_t mk(input logic rst, input logic st, input logic [3:0] op,
                               input logic z, input logic rdy, input logic chk,
                               input logic [12:0] exp, input int tag);
      vec_t v;
      v.rst = rst; v.st = st; v.op = op; v.z = z; v.rdy = rdy;
      v.chk = chk; v.exp = exp; v.tag = tag;
      return v;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [3:0] rop();
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic push(input logic rst, input logic st, input logic [3:0] op, input logic z,
                       input logic rdy, input logic [12:0] exp, input int tag);
      q.push_back(mk(rst, st, op, z, rdy, 1'b1, exp, tag));
   endtask

   // Instruction fetch: each stalled cycle reads, the completing cycle loads IR and bumps PC.
   task automatic do_fetch(input int waits);
      for (int i = 0; i < waits; i++) push(1'b0, rb(), rop(), rb(), 1'b0, B_MRD | B_BUSY, 10);
      push(1'b0, rb(), rop(), rb(), 1'b1, B_MRD | B_BUSY | B_IREN | B_PCEN, 11);
   endtask

   task automatic do_decode(input logic [3:0] op, input logic z);
      logic br;
      br = (op == 4'd7) || ((op == 4'd8) && z);
      push(1'b0, rb(), op, z, rb(), B_BUSY | (br ? (B_PCEN | B_PCSEL) : E_NONE), 20);
   endtask

   task automatic do_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
      logic [12:0] base;
      do_fetch(fw);
      do_decode(op, z);
      if (op == 4'd1 || (op >= 4'd3 && op <= 4'd6)) begin
         base = B_MRD | B_ASEL | B_BUSY | alu_field(op);
         for (int i = 0; i < mw; i++) push(1'b0, rb(), rop(), rb(), 1'b0, base, 30);
         push(1'b0, rb(), rop(), rb(), 1'b1, base | B_ACCEN, 31);
      end else if (op == 4'd2) begin
         base = B_MWR | B_ASEL | B_BUSY;
         for (int i = 0; i < mw; i++) push(1'b0, rb(), rop(), rb(), 1'b0, base, 40);
         push(1'b0, rb(), rop(), rb(), 1'b1, base, 41);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;

      // Directed ADD walk: reset 2 cycles, IDLE+start, FETCH, DECODE, MEM_RD, back to FETCH
      dir_tbl[0] = mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, E_NONE, 0);
      dir_tbl[1] = mk(1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, E_NONE, 1);
      dir_tbl[2] = mk(1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, E_NONE, 2);
      dir_tbl[3] = mk(1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, B_MRD | B_BUSY | B_IREN | B_PCEN, 3);
      dir_tbl[4] = mk(1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, B_BUSY, 4);
      dir_tbl[5] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1,
                      B_MRD | B_ASEL | B_BUSY | B_ACCEN | 13'h0008, 5);
      dir_tbl[6] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, B_MRD | B_BUSY, 6);
      foreach (dir_tbl[i]) q.push_back(dir_tbl[i]);

      // JZ not taken, then taken
      do_instr(4'h8, 1'b0, 0, 0);
      do_instr(4'h8, 1'b1, 1, 0);
      // STORE with a long memory stall
      do_instr(4'h2, 1'b0, 0, STORE_WAITS);

      // Reset in the middle of a LOAD read stall: no acc_en, IDLE next cycle
      do_fetch(0);
      do_decode(4'h1, 1'b0);
      push(1'b0, 1'b0, rop(), 1'b0, 1'b0, B_MRD | B_ASEL | B_BUSY, 50);
      push(1'b0, 1'b0, rop(), 1'b0, 1'b0, B_MRD | B_ASEL | B_BUSY, 50);
      push(1'b1, 1'b0, rop(), 1'b0, 1'b1, B_MRD | B_ASEL | B_BUSY, 51);
      push(1'b0, 1'b0, rop(), 1'b0, 1'b1, E_NONE, 52);
      push(1'b0, 1'b1, rop(), 1'b0, 1'b1, E_NONE, 53);

      // Randomized instruction stream (everything except HALT, illegal codes included)
      for (int n = 0; n < 150; n++)
         do_instr(4'($urandom_range(0, 14)), rb(), $urandom_range(0, 3), $urandom_range(0, 3));

`ifdef CPU_CTRL_TIMEOUT_EN
      // Ready on the 4th wait cycle wins; then 4 stalled cycles lead to FAULT
      do_instr(4'h0, 1'b0, 3, 0);
      for (int i = 0; i < 4; i++) push(1'b0, rb(), rop(), rb(), 1'b0, B_MRD | B_BUSY, 60);
      for (int i = 0; i < 3; i++) push(1'b0, 1'b1, rop(), rb(), rb(), B_FAULT, 61);
      push(1'b1, 1'b1, rop(), rb(), rb(), B_FAULT, 62);
      push(1'b0, 1'b1, rop(), rb(), rb(), E_NONE, 63);
`endif

      // HALT is absorbing until reset; start pulses ignored
      do_instr(4'hF, rb(), 1, 0);
      for (int i = 0; i < 6; i++) push(1'b0, rb(), rop(), rb(), rb(), B_HALT, 70);
      push(1'b1, 1'b1, rop(), rb(), rb(), B_HALT, 71);
      push(1'b0, 1'b0, rop(), rb(), rb(), E_NONE, 72);
      push(1'b0, 1'b0, rop(), rb(), rb(), E_NONE, 73);

      foreach (q[i]) begin
         logic [12:0] act;
         @(negedge clk);
         reset = q[i].rst; start = q[i].st; opcode = q[i].op;
         zero = q[i].z; mem_ready = q[i].rdy;
         #1;
         act = {pc_en, pc_sel, ir_en, acc_en, addr_sel, mem_rd, mem_wr, alu_op, busy, halted, fault};
         if (q[i].chk) begin
            n_cmp++;
            if (act !== q[i].exp) begin
               n_bad++;
               $display("FAIL vec%0d tag%0d outputs: got %013b want %013b", i, q[i].tag, act, q[i].exp);
            end
         end
         if (q[i].tag == 52) begin
            n_cmp++;
            if (act !== E_NONE) begin
               n_bad++;
               $display("FAIL vec%0d reset state: outputs %013b not all zero", i, act);
            end
         end
         if (q[i].tag == 61 || q[i].tag == 62) begin
            n_cmp++;
            if (fault !== 1'b1 || busy !== 1'b0) begin
               n_bad++;
               $display("FAIL vec%0d expired wait: fault=%b busy=%b", i, fault, busy);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
